// File: rtl/vga_capture_monitor_pkg.sv
// Shared widths, frame statistics record and checksum step for the VGA capture monitor.
package vga_mon_pkg;

    localparam int CNT_W  = 12;
    localparam int CSUM_W = 32;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic {
        ST_IDLE,
        ST_RUN
    } mon_state_t;

    typedef struct packed {
        logic [CNT_W-1:0] h_act;
        logic [CNT_W-1:0] v_act;
        logic [CNT_W-1:0] h_tot;
        logic [CNT_W-1:0] v_tot;
    } frame_stats_t;

    // One checksum step: rotate left by one, then fold in the 24-bit pixel.
    function automatic logic [CSUM_W-1:0] csum_step(input logic [CSUM_W-1:0] csum,
                                                     input logic [23:0]       px);
        return {csum[CSUM_W-2:0], csum[CSUM_W-1]} ^ {8'h00, px};
    endfunction

endpackage

// File: rtl/vga_capture_monitor_if.sv
// Pixel stream in, per-frame results out. The source side is the master.
interface vga_mon_if;
    import vga_mon_pkg::*;

    logic [7:0]        VGA_R;
    logic [7:0]        VGA_G;
    logic [7:0]        VGA_B;
    logic              VGA_HS;
    logic              VGA_VS;
    logic              VGA_DE;

    logic [CNT_W-1:0]  H_ACTIVE;
    logic [CNT_W-1:0]  V_ACTIVE;
    logic [CNT_W-1:0]  H_TOTAL;
    logic [CNT_W-1:0]  V_TOTAL;
    logic [CSUM_W-1:0] CHECKSUM;
    logic              FRAME_DONE;
    logic              GEOM_ERR;
    logic              LOCKED;

    modport master (
        output VGA_R, VGA_G, VGA_B, VGA_HS, VGA_VS, VGA_DE,
        input  H_ACTIVE, V_ACTIVE, H_TOTAL, V_TOTAL, CHECKSUM, FRAME_DONE, GEOM_ERR, LOCKED
    );

    modport slave (
        input  VGA_R, VGA_G, VGA_B, VGA_HS, VGA_VS, VGA_DE,
        output H_ACTIVE, V_ACTIVE, H_TOTAL, V_TOTAL, CHECKSUM, FRAME_DONE, GEOM_ERR, LOCKED
    );

endinterface

// File: rtl/vga_capture_monitor_sync_edge.sv
// Input registration, sync polarity normalisation and edge pulses.
// The pulses are registered, so pix/pix_de are delayed to stay aligned with them.
module vga_sync_edge #(
    parameter bit HS_NEG = 1'b1,
    parameter bit VS_NEG = 1'b1
) (
    input  logic        clk,
    input  logic        rst_b,
    input  logic [7:0]  r,
    input  logic [7:0]  g,
    input  logic [7:0]  b,
    input  logic        hs,
    input  logic        vs,
    input  logic        de,
    output logic [23:0] pix,
    output logic        pix_de,
    output logic        hs_e,
    output logic        vs_e,
    output logic        de_f
);

    logic [23:0] pix_s0;
    logic        hs_s0, vs_s0, de_s0;
    logic        hs_s1, vs_s1;

    // Two register stages: raw capture, then previous-value compare for edges.
    always_ff @(posedge clk) begin
        if (!rst_b) begin
            pix_s0 <= '0;
            hs_s0  <= 1'b0;
            vs_s0  <= 1'b0;
            de_s0  <= 1'b0;
            hs_s1  <= 1'b0;
            vs_s1  <= 1'b0;
            pix    <= '0;
            pix_de <= 1'b0;
            hs_e   <= 1'b0;
            vs_e   <= 1'b0;
            de_f   <= 1'b0;
        end else begin
            pix_s0 <= {r, g, b};
            hs_s0  <= hs ^ HS_NEG;
            vs_s0  <= vs ^ VS_NEG;
            de_s0  <= de;
            hs_s1  <= hs_s0;
            vs_s1  <= vs_s0;
            pix    <= pix_s0;
            pix_de <= de_s0;
            hs_e   <= hs_s0 & ~hs_s1;
            vs_e   <= vs_s0 & ~vs_s1;
            de_f   <= pix_de & ~de_s0;
        end
    end

endmodule

// File: rtl/vga_capture_monitor.sv
// Receive-side VGA checker: frame geometry, pixel checksum and lock status,
// published once per frame on the VS leading edge.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   ST_IDLE | after reset; first VS edge starts a frame without publishing
//   ST_RUN  | every VS edge publishes the ending frame and starts the next
module vga_capture_monitor
    import vga_mon_pkg::*;
#(
    parameter bit HS_NEG = 1'b1,
    parameter bit VS_NEG = 1'b1,
    parameter int EXP_H  = 640,
    parameter int EXP_V  = 480
) (
    input  logic     CLK,
    input  logic     RST,
    vga_mon_if.slave vga
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] EXP_H_C = CNT_W'(EXP_H);
    localparam logic [CNT_W-1:0] EXP_V_C = CNT_W'(EXP_V);

    logic [23:0]       pix;
    logic              pix_de, hs_e, vs_e, de_f;

    mon_state_t        state, state_n;
    logic [CNT_W-1:0]  hcnt, htot, derun, wref, vlines, hlines;
    logic [CNT_W-1:0]  hcnt_n, htot_n, derun_n, wref_n, vlines_n, hlines_n;
    logic              htot_seen, htot_seen_n, err, err_n;
    logic [CSUM_W-1:0] csum, csum_n;
    logic              publish, clear, geom_err;
    frame_stats_t      stats_n, stats_prev;

    vga_sync_edge #(.HS_NEG(HS_NEG), .VS_NEG(VS_NEG)) u_sync (
        .clk    (CLK),
        .rst_b  (RST),
        .r      (vga.VGA_R),
        .g      (vga.VGA_G),
        .b      (vga.VGA_B),
        .hs     (vga.VGA_HS),
        .vs     (vga.VGA_VS),
        .de     (vga.VGA_DE),
        .pix    (pix),
        .pix_de (pix_de),
        .hs_e   (hs_e),
        .vs_e   (vs_e),
        .de_f   (de_f)
    );

    // Frame state register.
    always_ff @(posedge CLK) begin
        if (!RST) state <= ST_IDLE;
        else      state <= state_n;
    end

    // Accumulator next values (including this cycle's events), publish decision and next state.
    always_comb begin
        hcnt_n      = hcnt;
        htot_n      = htot;
        htot_seen_n = htot_seen;
        derun_n     = derun;
        wref_n      = wref;
        vlines_n    = vlines;
        hlines_n    = hlines;
        csum_n      = csum;
        err_n       = err;
        state_n     = state;
        publish     = 1'b0;
        clear       = 1'b0;

        if (hs_e) begin
            hcnt_n      = CNT_ONE;
            htot_n      = hcnt;
            htot_seen_n = 1'b1;
            // a line edge coinciding with VS belongs to the next frame
            if (htot_seen && hcnt != htot && !vs_e) err_n = 1'b1;
            if (hlines == CNT_MAX) err_n = 1'b1;
            else                   hlines_n = hlines + 1'b1;
        end else if (hcnt == CNT_MAX) begin
            err_n = 1'b1;
        end else begin
            hcnt_n = hcnt + 1'b1;
        end

        if (pix_de) begin
            csum_n = csum_step(csum, pix);
            if (derun == CNT_MAX) err_n = 1'b1;
            else                  derun_n = derun + 1'b1;
        end

        if (de_f) begin
            derun_n = '0;
            if (vlines == '0)       wref_n = derun;
            else if (derun != wref) err_n  = 1'b1;
            if (vlines == CNT_MAX) err_n = 1'b1;
            else                   vlines_n = vlines + 1'b1;
        end

        if (vs_e && pix_de) err_n = 1'b1;

        geom_err   = err_n | (wref_n != EXP_H_C) | (vlines_n != EXP_V_C);
        stats_n    = '{h_act: wref_n, v_act: vlines_n, h_tot: htot, v_tot: hlines};
        stats_prev = '{h_act: vga.H_ACTIVE, v_act: vga.V_ACTIVE,
                       h_tot: vga.H_TOTAL,  v_tot: vga.V_TOTAL};

        case (state)
            ST_IDLE: if (vs_e) begin
                state_n = ST_RUN;
                clear   = 1'b1;
            end
            ST_RUN: if (vs_e) begin
                publish = 1'b1;
                clear   = 1'b1;
            end
            default: state_n = ST_IDLE;
        endcase
    end

    // Accumulators and published result registers.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            hcnt           <= '0;
            htot           <= '0;
            htot_seen      <= 1'b0;
            derun          <= '0;
            wref           <= '0;
            vlines         <= '0;
            hlines         <= '0;
            csum           <= '0;
            err            <= 1'b0;
            vga.H_ACTIVE   <= '0;
            vga.V_ACTIVE   <= '0;
            vga.H_TOTAL    <= '0;
            vga.V_TOTAL    <= '0;
            vga.CHECKSUM   <= '0;
            vga.FRAME_DONE <= 1'b0;
            vga.GEOM_ERR   <= 1'b0;
            vga.LOCKED     <= 1'b0;
        end else begin
            hcnt <= hcnt_n;
            htot <= htot_n;
            if (clear) begin
                // the period ending on the frame's first line edge spans two frames
                htot_seen <= 1'b0;
                derun     <= '0;
                wref      <= '0;
                vlines    <= '0;
                hlines    <= {{(CNT_W-1){1'b0}}, hs_e};
                csum      <= '0;
                err       <= 1'b0;
            end else begin
                htot_seen <= htot_seen_n;
                derun     <= derun_n;
                wref      <= wref_n;
                vlines    <= vlines_n;
                hlines    <= hlines_n;
                csum      <= csum_n;
                err       <= err_n;
            end
            vga.FRAME_DONE <= publish;
            if (publish) begin
                vga.H_ACTIVE <= stats_n.h_act;
                vga.V_ACTIVE <= stats_n.v_act;
                vga.H_TOTAL  <= stats_n.h_tot;
                vga.V_TOTAL  <= stats_n.v_tot;
                vga.CHECKSUM <= csum_n;
                vga.GEOM_ERR <= geom_err;
                vga.LOCKED   <= ~geom_err & (stats_n == stats_prev);
            end
        end
    end

endmodule
